// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - Core-side request/response bundle for the data-memory responder.
interface dmem_resp_if;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [15:0] addr_i;
    logic [15:0] wdata_i;
    logic [15:0] rdata_o;
    logic        rvalid_o;
    logic        ack_o;
    logic        stall_o;
    logic        err_o;

    modport master (
        output mem_read_i, mem_write_i, addr_i, wdata_i,
        input  rdata_o, rvalid_o, ack_o, stall_o, err_o
    );

    modport slave (
        input  mem_read_i, mem_write_i, addr_i, wdata_i,
        output rdata_o, rvalid_o, ack_o, stall_o, err_o
    );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - Fixed-latency word-organised data memory that stalls the core per access.
module dmem_resp #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dmem_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              is_read_q, is_read_d;
    logic              illegal_q, illegal_d;
    logic              req;
    logic              mem_we;
    logic              unused_addr;
    logic [15:0]       mem_q [0:(1<<ADDR_W)-1];

    assign req         = bus.mem_read_i | bus.mem_write_i;
    // Upper byte-address bits are dropped so the array aliases.
    assign unused_addr = ^bus.addr_i[15:ADDR_W+1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        illegal_d = illegal_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    widx_d    = bus.addr_i[ADDR_W:1];
                    wdata_d   = bus.wdata_i;
                    is_read_d = bus.mem_read_i;
                    illegal_d = bus.addr_i[0] | (bus.mem_read_i & bus.mem_write_i);
                    cnt_d     = 4'(LATENCY - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (illegal_q) begin
                        rdata_d = '0;
                    end else if (is_read_q) begin
                        rdata_d = mem_q[widx_q];
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            widx_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            is_read_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            is_read_q <= is_read_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[widx_q] <= wdata_q;
        end
    end

    assign bus.stall_o  = (state_q == IDLE) ? req : (state_q == WAIT);
    assign bus.ack_o    = (state_q == DONE);
    assign bus.err_o    = (state_q == DONE) && illegal_q;
    assign bus.rvalid_o = (state_q == DONE) && is_read_q && !illegal_q;
    assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - Scoreboard bench for dmem_resp at LATENCY 2 and LATENCY 1.
module tb_dmem_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_resp_if if0();
    dmem_resp_if if1();

    dmem_resp #(.ADDR_W(8), .LATENCY(2)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    dmem_resp #(.ADDR_W(8), .LATENCY(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1));

    typedef struct {
        bit          err;
        bit          load;
        bit          known;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] ref_mem[int];
    logic [15:0] last_rd[2];
    bit          last_known[2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_in(int sel, bit rd, bit wr, logic [15:0] a, logic [15:0] d);
        if (sel == 0) begin
            if0.mem_read_i = rd; if0.mem_write_i = wr; if0.addr_i = a; if0.wdata_i = d;
        end else begin
            if1.mem_read_i = rd; if1.mem_write_i = wr; if1.addr_i = a; if1.wdata_i = d;
        end
    endtask

    task automatic scramble(int sel);
        if (sel == 0) begin
            if0.addr_i = 16'($urandom); if0.wdata_i = 16'($urandom);
        end else begin
            if1.addr_i = 16'($urandom); if1.wdata_i = 16'($urandom);
        end
    endtask

    function automatic logic get_stall(int sel);
        return (sel == 0) ? if0.stall_o : if1.stall_o;
    endfunction

    // Issue one access, push its predicted outcome, and hold it through completion.
    task automatic do_req(int sel, bit rd, bit wr, logic [15:0] a, logic [15:0] d);
        int   lat = (sel == 0) ? 2 : 1;
        int   key = sel * 1024 + int'(a[8:1]);
        bit   ill = a[0] | (rd & wr);
        exp_t e;
        set_in(sel, rd, wr, a, d);
        e.cyc  = cyc + lat + 1;
        e.err  = ill;
        e.load = rd && !ill;
        if (ill) begin
            e.known = 1'b1; e.data = '0;
        end else if (rd) begin
            e.known = ref_mem.exists(key);
            e.data  = e.known ? ref_mem[key] : 16'h0;
        end else begin
            ref_mem[key] = d;
            e.known = last_known[sel];
            e.data  = last_rd[sel];
        end
        if (ill || rd) begin
            last_rd[sel] = e.data; last_known[sel] = e.known;
        end
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        for (int i = 0; i <= lat + 1; i++) begin
            @(negedge clk);
            chk((sel == 0) ? "stall0" : "stall1", 32'(get_stall(sel)), 32'(i <= lat));
            @(posedge clk);
            #1;
            if (i < lat) scramble(sel);
        end
    endtask

    task automatic idle(int sel, int n);
        set_in(sel, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("stall_idle", 32'(get_stall(sel)), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                logic        ack, rv, er;
                logic [15:0] rd;
                bit          have;
                exp_t        e;
                ack  = (s == 0) ? if0.ack_o    : if1.ack_o;
                rv   = (s == 0) ? if0.rvalid_o : if1.rvalid_o;
                er   = (s == 0) ? if0.err_o    : if1.err_o;
                rd   = (s == 0) ? if0.rdata_o  : if1.rdata_o;
                have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (have) e = (s == 0) ? q0[0] : q1[0];
                if (ack) begin
                    if (!have) begin
                        chk("spurious_ack", 32'(ack), 32'd0);
                    end else begin
                        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                        chk("err", 32'(er), 32'(e.err));
                        chk("rvalid", 32'(rv), 32'(e.load));
                        if (e.known) chk("rdata", 32'(rd), 32'(e.data));
                        if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    end
                end else begin
                    if (rv || er) chk("pulse_without_ack", 32'({rv, er}), 32'd0);
                    if (have && e.cyc < cyc) begin
                        chk("missing_ack", 32'(cyc), 32'(e.cyc));
                        if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_in(1, 1'b0, 1'b0, 16'h0, 16'h0);
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
        last_known[0] = 1'b1; last_known[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rdata", 32'(if0.rdata_o), 32'h0);
        chk("rst_rvalid", 32'(if0.rvalid_o), 32'h0);
        chk("rst_ack", 32'(if0.ack_o), 32'h0);
        chk("rst_err", 32'(if0.err_o), 32'h0);
        chk("rst_stall", 32'(if0.stall_o), 32'h0);

        do_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        idle(0, 1);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        do_req(0, 1'b1, 1'b0, 16'h0011, 16'h0);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        do_req(0, 1'b0, 1'b1, 16'h0020, 16'h0F0F);
        do_req(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        do_req(0, 1'b1, 1'b0, 16'h0020, 16'h0);
        do_req(0, 1'b0, 1'b1, 16'h0030, 16'h1111);
        idle(0, 1);

        set_in(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
        @(posedge clk);
        #1 rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 16'h0030, 16'hAAAA);
        #1;
        chk("abort_ack", 32'(if0.ack_o), 32'h0);
        chk("abort_stall", 32'(if0.stall_o), 32'h0);
        chk("abort_rvalid", 32'(if0.rvalid_o), 32'h0);
        chk("abort_err", 32'(if0.err_o), 32'h0);
        chk("abort_rdata0", 32'(if0.rdata_o), 32'h0);
        chk("abort_rdata1", 32'(if1.rdata_o), 32'h0);
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
        last_known[0] = 1'b1; last_known[1] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(0, 3);
        do_req(0, 1'b1, 1'b0, 16'h0030, 16'h0);

        do_req(0, 1'b0, 1'b1, 16'h0002, 16'h5555);
        do_req(0, 1'b0, 1'b1, 16'h0202, 16'h6666);
        do_req(0, 1'b1, 1'b0, 16'h0002, 16'h0);
        idle(0, 1);

        do_req(1, 1'b0, 1'b1, 16'h0040, 16'h7777);
        do_req(1, 1'b1, 1'b0, 16'h0040, 16'h0);
        idle(1, 2);

        for (int n = 0; n < 80; n++) begin
            int          r = int'($urandom_range(0, 9));
            logic [15:0] a = 16'($urandom);
            bit          rd, wr;
            a[8:1] = 8'($urandom_range(0, 7));
            a[0]   = (r == 9);
            rd = (r >= 4 && r <= 8) || (r == 9 && n[0]);
            wr = (r <= 3) || (r == 8) || (r == 9 && !n[0]);
            do_req(0, rd, wr, a, 16'($urandom));
            idle(0, int'($urandom_range(0, 2)));
        end

        idle(0, 4);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the 16-bit core: the far end of the `mem_read_o`/`mem_write_o` request lines produced by the control unit. It accepts one load or store at a time, holds the core with `stall_o` for a fixed number of wait states, then completes the access against an internal word-organised array. It returns read data with a one-cycle valid strobe and flags malformed requests.

## Interface
- `ADDR_W`, 8: word-index width; array depth is 2^ADDR_W 16-bit words.
- `LATENCY`, 2: wait states per access; legal range 1..15.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `mem_read_i` input 1: load request; held by the core until completion.
- `mem_write_i` input 1: store request; held by the core until completion.
- `addr_i` input 16: byte address.
- `wdata_i` input 16: store data.
- `rdata_o` output 16: load data, registered.
- `rvalid_o` output 1: `rdata_o` valid this cycle (load completion).
- `ack_o` output 1: access complete this cycle (load or store).
- `stall_o` output 1: core must hold its request and not advance.
- `err_o` output 1: completed request was illegal.

## Operation
- States: IDLE, WAIT, DONE. `req = mem_read_i | mem_write_i`.
- **IDLE**
  - `stall_o = req`; this is combinational from the inputs.
  - On `req`: capture `addr_i`, `wdata_i` and the op; load the counter with LATENCY-1; go to WAIT.
- **WAIT**
  - `stall_o = 1`.
  - Counter nonzero: decrement it.
  - Counter zero: perform the captured access at this edge, then go to DONE.
  - Input changes during WAIT are ignored; only captured values are used.
- **Perform**
  - Word index is `addr[ADDR_W:1]`. Address bits above ADDR_W are ignored, so addresses alias.
  - Store: write the array.
  - Load: register the array word into `rdata_o`.
- **DONE**
  - `stall_o = 0`, `ack_o = 1`. `rvalid_o = 1` if the op was a load.
  - Always returns to IDLE. The request still present during DONE is the completed one and is not re-accepted.
- **Illegal requests**
  - Illegal means `addr[0] = 1` (misaligned) or both `mem_read_i` and `mem_write_i` asserted at capture.
  - An illegal request still goes through full WAIT timing.
  - At perform: no array write, `rdata_o <= 0`.
  - In DONE: `err_o = 1`, `ack_o = 1`, `rvalid_o = 0`.
- `rdata_o` holds its value until the next load completes (or an illegal request clears it).
- The array is not reset; contents are undefined until written.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `rdata_o = 0`, `rvalid_o = 0`, `ack_o = 0`, `err_o = 0`.
  - `stall_o` follows `req` combinationally once in IDLE.
- The request arrives in cycle 0. `stall_o` is high in cycles 0..LATENCY. Completion (`ack_o`, and `rvalid_o` for loads) is in cycle LATENCY+1. Total occupancy is LATENCY+2 cycles.
- Back-to-back: a new request seen in the cycle after DONE is accepted immediately. Throughput is one access per LATENCY+2 cycles.
- `ack_o`, `rvalid_o` and `err_o` are one-cycle pulses, driven only in DONE.
- Reset asserted during WAIT:
  - Aborts immediately; the state returns to IDLE.
  - The store is not performed if reset precedes the perform edge.
  - No ack is produced.
- A request dropped by the core during WAIT still completes; DONE is produced. The core must not do this.
- `rdata_o` and the array update on the same edge. A load issued right after a store to the same address returns the new data.

## Test plan
- **Store then load, LATENCY=2.** Store 0xBEEF to addr 0x0010; `stall_o` high in cycles 0-2; `ack_o` in cycle 3. Then load 0x0010: `rvalid_o` and `ack_o` in cycle 3 with `rdata_o = 0xBEEF`.
- **Misaligned load.** Load 0x0011: `stall_o` in cycles 0-2; cycle 3 has `err_o = 1`, `ack_o = 1`, `rvalid_o = 0`, `rdata_o = 0`. A subsequent aligned load of 0x0010 still returns 0xBEEF.
- **Both requests asserted.** Assert `mem_read_i` and `mem_write_i` with addr 0x0020, wdata 0x1234: `err_o` in cycle 3. A later load of 0x0020 does not return 0x1234.
- **Reset mid-access.** Start a store of 0xAAAA to 0x0030; pulse `rst_i` in cycle 1: no `ack_o`, all outputs 0, and a later load of 0x0030 does not return 0xAAAA.
- **Back-to-back and aliasing.** Store 0x5555 to 0x0002, then immediately store 0x6666 to 0x0202 (ADDR_W=8, aliases word 1). Each occupies exactly 4 cycles; a load of 0x0002 then returns 0x6666.
- **LATENCY=1 build.** A load shows `stall_o` for cycles 0-1 and `rvalid_o` in cycle 2. Input changes to `addr_i` during WAIT do not affect the returned data.
